// File: rtl/wbuff_pkg.sv
// Shared types, default sizes and width helper for the weight buffer write path.
package wbuff_pkg;

    typedef enum logic [1:0] {IDLE, FILL, DONE} wbuff_state_e;

    localparam int NB_PE_COL    = 16;
    localparam int BUFFER_DEPTH = 72;
    localparam int BUFFER_WIDTH = 16;

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wbuff_write_ctrl_if.sv
// Weight stream in, per-column buffer write port out.
interface wbuff_write_ctrl_if import wbuff_pkg::*; #(
    parameter int nb_pe_col         = NB_PE_COL,
    parameter int buffer_depth      = BUFFER_DEPTH,
    parameter int buffer_width      = BUFFER_WIDTH,
    parameter int buffer_addr_width = clogb2(buffer_depth)
) ();

    logic [buffer_width-1:0]                     s_data;
    logic                                        s_valid;
    logic                                        s_ready;
    logic [nb_pe_col-1:0][buffer_addr_width-1:0] wAddr;
    logic [nb_pe_col-1:0][buffer_width-1:0]      buffer_data_in;
    logic [nb_pe_col-1:0]                        buffer_wEn_AH;

    modport master (
        output s_data, s_valid,
        input  s_ready, wAddr, buffer_data_in, buffer_wEn_AH
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, wAddr, buffer_data_in, buffer_wEn_AH
    );

endinterface

// File: rtl/wbuff_fill_cnt.sv
// Column/address counter pair for an interleaved fill: columns advance first, then the address.
module wbuff_fill_cnt import wbuff_pkg::*; #(
    parameter int nb_pe_col         = NB_PE_COL,
    parameter int buffer_depth      = BUFFER_DEPTH,
    parameter int buffer_addr_width = clogb2(buffer_depth),
    parameter int col_idx_width     = clogb2(nb_pe_col)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         adv,
    input  logic                         clr,
    input  logic [col_idx_width:0]       nb_cols,
    input  logic [buffer_addr_width:0]   words_per_col,
    output logic [col_idx_width-1:0]     col,
    output logic [buffer_addr_width-1:0] addr,
    output logic                         last
);

    logic col_last;
    logic addr_last;

    assign col_last  = ({1'b0, col}  == nb_cols - (col_idx_width + 1)'(1));
    assign addr_last = ({1'b0, addr} == words_per_col - (buffer_addr_width + 1)'(1));
    assign last      = col_last && addr_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col  <= '0;
            addr <= '0;
        end else if (adv) begin
            if (col_last) begin
                col  <= '0;
                addr <= addr + buffer_addr_width'(1);
            end else begin
                col  <= col + col_idx_width'(1);
            end
        end
    end

endmodule

// File: rtl/wbuff_write_ctrl.sv
// Weight-load job controller: scatters a word stream across the column buffers, one write per beat.
module wbuff_write_ctrl import wbuff_pkg::*; #(
    parameter int nb_pe_col         = NB_PE_COL,
    parameter int buffer_depth      = BUFFER_DEPTH,
    parameter int buffer_width      = BUFFER_WIDTH,
    parameter int buffer_addr_width = clogb2(buffer_depth),
    parameter int col_idx_width     = clogb2(nb_pe_col)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [buffer_addr_width:0] cfg_words_per_col,
    input  logic [col_idx_width:0]     cfg_nb_cols,
    wbuff_write_ctrl_if.slave          bus,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err
);

    localparam logic [buffer_addr_width:0] W_MAX = (buffer_addr_width + 1)'(buffer_depth);
    localparam logic [col_idx_width:0]     C_MAX = (col_idx_width + 1)'(nb_pe_col);

    wbuff_state_e                 state_q, state_d;
    logic [col_idx_width:0]       nb_cols_q;
    logic [buffer_addr_width:0]   words_q;
    logic [col_idx_width-1:0]     col;
    logic [buffer_addr_width-1:0] addr;
    logic                         last;
    logic                         cfg_ok;
    logic                         start_ok;
    logic                         hs;
    logic                         ready;
    logic                         cfg_err_p1;

    logic [nb_pe_col-1:0]                        wen_p1;
    logic [nb_pe_col-1:0][buffer_addr_width-1:0] waddr_p1;
    logic [nb_pe_col-1:0][buffer_width-1:0]      wdata_p1;

    assign cfg_ok   = (cfg_words_per_col != '0) && (cfg_words_per_col <= W_MAX) &&
                      (cfg_nb_cols != '0) && (cfg_nb_cols <= C_MAX);
    assign start_ok = (state_q == IDLE) && start && cfg_ok;
    // abort wins over a same-cycle beat, so that beat is neither written nor counted
    assign hs       = (state_q == FILL) && bus.s_valid && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = FILL;
            end
            FILL: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (abort)           state_d = IDLE;
                else if (hs && last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nb_cols_q  <= '0;
            words_q    <= '0;
            cfg_err_p1 <= 1'b0;
        end else begin
            cfg_err_p1 <= (state_q == IDLE) && start && !cfg_ok;
            if (start_ok) begin
                nb_cols_q <= cfg_nb_cols;
                words_q   <= cfg_words_per_col;
            end
        end
    end

    wbuff_fill_cnt #(
        .nb_pe_col         (nb_pe_col),
        .buffer_depth      (buffer_depth),
        .buffer_addr_width (buffer_addr_width),
        .col_idx_width     (col_idx_width)
    ) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .adv           (hs),
        .clr           (start_ok),
        .nb_cols       (nb_cols_q),
        .words_per_col (words_q),
        .col           (col),
        .addr          (addr),
        .last          (last)
    );

    // Stage p1: only the addressed column's address/data registers load, idle columns hold
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_p1   <= '0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            wen_p1 <= '0;
            if (hs) begin
                wen_p1[col]   <= 1'b1;
                waddr_p1[col] <= addr;
                wdata_p1[col] <= bus.s_data;
            end
        end
    end

    assign bus.s_ready        = ready;
    assign bus.buffer_wEn_AH  = wen_p1;
    assign bus.wAddr          = waddr_p1;
    assign bus.buffer_data_in = wdata_p1;
    assign cfg_err            = cfg_err_p1;

endmodule

// File: doc/wbuff_write_ctrl.md
Name: wbuff_write_ctrl

Overview:
- Producer side of the per-column weight buffer write port.
- Accepts one valid/ready stream of weight words from the DMA/loader.
- Scatters the words across `nb_pe_col` column buffer banks by driving, per column, the write address, write data and active-high write enable.
- Fills one weight-load job at a time, then reports done; it sits between the weight DMA and the weight buffer array.

Parameters:
- `nb_pe_col`, 16, number of PE columns / buffer banks.
- `buffer_depth`, 72, words per column buffer.
- `buffer_width`, 16, word width in bits.
- `buffer_addr_width`, clogb2(`buffer_depth`) (=7), buffer address width.
- `col_idx_width`, clogb2(`nb_pe_col`) (=4), column index width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle job start; sampled only in IDLE.
- `abort`  in  1  cancels the job in FILL.
- `cfg_words_per_col`  in  `buffer_addr_width`+1  words per column; legal range 1..`buffer_depth`.
- `cfg_nb_cols`  in  `col_idx_width`+1  active columns; legal range 1..`nb_pe_col`.
- `s_data`  in  `buffer_width`  stream word.
- `s_valid`  in  1  stream valid.
- `s_ready`  out  1  stream ready.
- `wAddr`  out  [`nb_pe_col`][`buffer_addr_width`]  per-column write address.
- `buffer_data_in`  out  [`nb_pe_col`][`buffer_width`]  per-column write data.
- `buffer_wEn_AH`  out  [`nb_pe_col`]  per-column write enable, active high.
- `busy`  out  1  high in FILL.
- `done`  out  1  one-cycle pulse at job completion.
- `cfg_err`  out  1  one-cycle pulse when `start` arrives with an illegal config.

Behaviour:
- Clock and reset:
  - One clock `clk`; reset `rst` is synchronous and active-high.
  - Reset is honoured in any state, including mid-FILL.
- Reset values:
  - State is IDLE.
  - `s_ready`, `busy`, `done`, `cfg_err` are 0.
  - All `wAddr` and `buffer_data_in` are 0; all `buffer_wEn_AH` are 0.
  - Column and address counters are 0.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - `s_ready`=0.
  - `start` with a legal config: latch `cfg_words_per_col` → W and `cfg_nb_cols` → C; col=0, addr=0; next state FILL.
  - `start` with an illegal config (W==0, W>`buffer_depth`, C==0, C>`nb_pe_col`): `cfg_err`=1 on the next cycle; stay in IDLE.
- FILL:
  - `s_ready`=1 and `busy`=1, both combinational from state.
  - A handshake is `s_valid` && `s_ready`.
  - On handshake at cycle T, the outputs registered at T+1 are:
    - `buffer_wEn_AH[col]`=1;
    - `wAddr[col]`=addr;
    - `buffer_data_in[col]`=`s_data`.
  - Word k of the job therefore lands in column k mod C at address k div C (interleaved fill; a tap is spread across columns first).
  - Counter update: if col==C-1 then col=0 and addr=addr+1, else col=col+1.
  - The handshake with col==C-1 and addr==W-1 is the last one (total C*W beats); next state DONE.
  - `abort` has priority over a same-cycle handshake: that beat is not written, and next state is IDLE with no `done`.
  - `start` is ignored in FILL.
- DONE:
  - `done`=1 for exactly one cycle, coincident with the final write enable. Latency from final handshake to `done` is 1 cycle.
  - `s_ready`=0; next state IDLE.
  - A `start` arriving in DONE is ignored.
- Per-column output registers:
  - `buffer_wEn_AH[i]` is 0 every cycle in which column i is not written.
  - `wAddr[i]` and `buffer_data_in[i]` hold their last written values when not written. This is a power requirement: no toggling on idle columns.
  - At most one column has write enable asserted per cycle.
  - Columns ≥ C are never written during the job.
- `s_valid` low in FILL: no write, counters hold, no timeout.
- `s_data` is ignored when no handshake occurs.

Decomposition:
- Shared package `wbuff_pkg`:
  - `wbuff_state_e` (IDLE/FILL/DONE);
  - defaults for `NB_PE_COL`, `BUFFER_DEPTH`, `BUFFER_WIDTH`;
  - the `clogb2` function.
- One sub-module, `wbuff_fill_cnt`: the column/address counter pair with terminal detect (inputs: `adv`, `clr`, C, W; outputs: col, addr, last).
- The top-level module holds the FSM and the per-column output registers.

Test Plan:
- Basic fill: C=16, W=4, 64 words 0..63 with `s_valid` held high → word k written to column k%16 at address k/16, one write enable per cycle. `done` pulses at cycle 65 after the first handshake, coincident with col15/addr3 data=63.
- Partial columns with backpressure: C=3, W=72, `s_valid` toggled 1-0. Expected: 216 writes; column 2 address 71 holds word 215; columns 3..15 write enables never assert; idle-column address/data registers never change.
- Illegal configs: W=0, W=73, C=0, C=17 → `cfg_err` pulse, stay IDLE, `s_ready`=0. Then a legal start proceeds normally.
- Abort: C=4, W=2; abort after 5 beats with `s_valid` high in the same cycle → beat 6 is not written, no `done`, IDLE next cycle. A restart then writes column 0 address 0 first.
- Reset mid-FILL: `rst` after 10 beats → next cycle all outputs 0 and `s_ready`=0; `start` during FILL and DONE is ignored.
- Back-to-back jobs: `start` asserted in the cycle after `done` → second job begins with column 0 address 0, and no stray write enable occurs between the jobs.
